bank_mode_controller: RTL and testbench

BANK_MODE_CONTROLLER -- requirements
Module: bank_mode_controller

---
 rtl/bank_mode_controller_pkg.sv | 50 +++++
 rtl/bank_mode_controller.sv | 124 ++++++++++++
 tb/tb_bank_mode_controller.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/bank_mode_controller_pkg.sv
// bank_mode_controller_pkg
// Shared definitions for the register-bank mode controller and the register
// bank itself.
// Contents:
//   bmc_state_e  - FSM state encoding (USER, ENTER, KERNEL, EXIT)
//   CTRL_*       - register-bank control codes understood by the bank
//   KIND_*       - write-back request kinds issued by the instruction sequencer
//   is_plain_kind / plain_code - helpers for the kinds that only write the bank
package bank_mode_controller_pkg;

  typedef enum logic [1:0] {
    ST_USER   = 2'd0,
    ST_ENTER  = 2'd1,
    ST_KERNEL = 2'd2,
    ST_EXIT   = 2'd3
  } bmc_state_e;

  localparam logic [2:0] CTRL_NONE  = 3'd0;
  localparam logic [2:0] CTRL_ALU   = 3'd1;
  localparam logic [2:0] CTRL_MEM   = 3'd2;
  localparam logic [2:0] CTRL_ENTER = 3'd3;
  localparam logic [2:0] CTRL_EXIT  = 3'd4;
  localparam logic [2:0] CTRL_CPXR  = 3'd5;

  localparam logic [2:0] KIND_PCSP   = 3'd0;
  localparam logic [2:0] KIND_ALU    = 3'd1;
  localparam logic [2:0] KIND_MEM    = 3'd2;
  localparam logic [2:0] KIND_SWI    = 3'd3;
  localparam logic [2:0] KIND_RETURN = 3'd4;
  localparam logic [2:0] KIND_CPXR   = 3'd5;

  // Kinds that are legal in both USER and KERNEL and never change mode.
  function automatic logic is_plain_kind(input logic [2:0] kind);
    return (kind == KIND_PCSP) || (kind == KIND_ALU) ||
           (kind == KIND_MEM)  || (kind == KIND_CPXR);
  endfunction

  // Control code the bank needs for a plain write-back kind.
  function automatic logic [2:0] plain_code(input logic [2:0] kind);
    logic [2:0] code;
    case (kind)
      KIND_ALU:  code = CTRL_ALU;
      KIND_MEM:  code = CTRL_MEM;
      KIND_CPXR: code = CTRL_CPXR;
      default:   code = CTRL_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bank_mode_controller.sv
// bank_mode_controller
// Sequences register-bank write-backs and user/kernel mode changes (software
// interrupts, external interrupts and returns).
// Parameters:
//   CTRL_WIDTH  - width of the register-bank control code
//   IRQ_ENABLED - 0 makes irq_req ignored entirely
// Ports:
//   slow_clock  in   sole clock, rising edge
//   reset       in   synchronous active-high reset
//   step        in   write-back request, held until accepted (step & ~busy)
//   wb_kind     in   0 PC/SP, 1 ALU, 2 MEM, 3 SWI, 4 RETURN, 5 CPXR, 6/7 illegal
//   irq_req     in   level-sensitive external interrupt request
//   rb_enable   out  register-bank write enable (one cycle per write-back)
//   rb_control  out  register-bank control code
//   vector_sel  out  selects the IRQ vector for the syscall-code mux
//   irq_ack     out  one-cycle acknowledge of a taken interrupt
//   privileged  out  high while in kernel mode
//   busy        out  high in ENTER and EXIT; steps are not accepted then
//   fault       out  sticky illegal-request flag
module bank_mode_controller
  import bank_mode_controller_pkg::*;
#(
  parameter int CTRL_WIDTH  = 3,
  parameter int IRQ_ENABLED = 1
) (
  input  logic                  slow_clock,
  input  logic                  reset,
  input  logic                  step,
  input  logic [2:0]            wb_kind,
  input  logic                  irq_req,
  output logic                  rb_enable,
  output logic [CTRL_WIDTH-1:0] rb_control,
  output logic                  vector_sel,
  output logic                  irq_ack,
  output logic                  privileged,
  output logic                  busy,
  output logic                  fault
);

  bmc_state_e state;
  logic       accept;
  logic       irq_take;

  assign accept   = step & ~busy;
  assign irq_take = (IRQ_ENABLED != 0) && irq_req;

  // All outputs are registered: every edge computes the next state together
  // with the outputs that belong to that next cycle. The one-shot outputs
  // default to zero so each write-back lasts exactly one cycle. An irq is only
  // looked at in USER, so a request that arrives while a SWI wins, or while in
  // KERNEL/EXIT, stays pending by virtue of being level-sensitive.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state      <= ST_USER;
      rb_enable  <= 1'b0;
      rb_control <= '0;
      vector_sel <= 1'b0;
      irq_ack    <= 1'b0;
      privileged <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      rb_enable  <= 1'b0;
      rb_control <= '0;
      vector_sel <= 1'b0;
      irq_ack    <= 1'b0;
      busy       <= 1'b0;
      case (state)
        ST_USER: begin
          privileged <= 1'b0;
          if (accept) begin
            rb_enable <= 1'b1;
            if (is_plain_kind(wb_kind)) begin
              rb_control <= CTRL_WIDTH'(plain_code(wb_kind));
            end else if (wb_kind == KIND_SWI) begin
              state      <= ST_ENTER;
              rb_control <= CTRL_WIDTH'(CTRL_ENTER);
              busy       <= 1'b1;
            end else begin
              fault      <= 1'b1;
              rb_control <= CTRL_WIDTH'(CTRL_NONE);
            end
          end else if (irq_take) begin
            state      <= ST_ENTER;
            rb_enable  <= 1'b1;
            rb_control <= CTRL_WIDTH'(CTRL_ENTER);
            vector_sel <= 1'b1;
            irq_ack    <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_ENTER: begin
          state      <= ST_KERNEL;
          privileged <= 1'b1;
        end
        ST_KERNEL: begin
          privileged <= 1'b1;
          if (accept) begin
            rb_enable <= 1'b1;
            if (is_plain_kind(wb_kind)) begin
              rb_control <= CTRL_WIDTH'(plain_code(wb_kind));
            end else if (wb_kind == KIND_RETURN) begin
              state      <= ST_EXIT;
              rb_control <= CTRL_WIDTH'(CTRL_EXIT);
              busy       <= 1'b1;
            end else begin
              fault      <= 1'b1;
              rb_control <= CTRL_WIDTH'(CTRL_NONE);
            end
          end
        end
        ST_EXIT: begin
          state      <= ST_USER;
          privileged <= 1'b0;
        end
        default: begin
          state      <= ST_USER;
          privileged <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bank_mode_controller.sv
// tb_bank_mode_controller
// Directed vectors with hand-computed expected outputs. Each vector drives the
// inputs for one cycle and pushes the outputs expected after the next edge
// into a scoreboard queue; a separate monitor pops and compares at the
// falling edge of the cycle the expectation belongs to.
module tb_bank_mode_controller;

  logic       slow_clock = 1'b0;
  logic       reset;
  logic       step;
  logic [2:0] wb_kind;
  logic       irq_req;
  logic       rb_enable;
  logic [2:0] rb_control;
  logic       vector_sel;
  logic       irq_ack;
  logic       privileged;
  logic       busy;
  logic       fault;

  typedef struct {
    int cyc;
    int en;
    int ctrl;
    int vsel;
    int ack;
    int priv;
    int bsy;
    int flt;
  } exp_t;

  exp_t expQ[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  bank_mode_controller #(
    .CTRL_WIDTH  (3),
    .IRQ_ENABLED (1)
  ) dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .step       (step),
    .wb_kind    (wb_kind),
    .irq_req    (irq_req),
    .rb_enable  (rb_enable),
    .rb_control (rb_control),
    .vector_sel (vector_sel),
    .irq_ack    (irq_ack),
    .privileged (privileged),
    .busy       (busy),
    .fault      (fault)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 slow_clock = ~slow_clock;

  // Edge counter shared by the stimulus and the monitor to tag expectations.
  always @(posedge slow_clock) cyc <= cyc + 1;

  task automatic checkField(input string name, input int act, input int exp, input int c);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL cycle %0d %s: got %0d expected %0d", c, name, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("rb_enable",  int'(rb_enable),  e.en,   e.cyc);
    checkField("rb_control", int'(rb_control), e.ctrl, e.cyc);
    checkField("vector_sel", int'(vector_sel), e.vsel, e.cyc);
    checkField("irq_ack",    int'(irq_ack),    e.ack,  e.cyc);
    checkField("privileged", int'(privileged), e.priv, e.cyc);
    checkField("busy",       int'(busy),       e.bsy,  e.cyc);
    checkField("fault",      int'(fault),      e.flt,  e.cyc);
  endtask

  // Monitor: compares the DUT against whatever expectation belongs to the
  // current cycle, sampled mid-cycle away from the rising edge.
  always @(negedge slow_clock) begin
    while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
      checkOutput(expQ.pop_front());
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic applyStimulus(input int r, input int s, input int k, input int i,
                               input int en, input int ctrl, input int vsel,
                               input int ack, input int priv, input int bsy,
                               input int flt);
    exp_t e;
    reset   = r[0];
    step    = s[0];
    wb_kind = k[2:0];
    irq_req = i[0];
    e.cyc  = cyc + 1;
    e.en   = en;
    e.ctrl = ctrl;
    e.vsel = vsel;
    e.ack  = ack;
    e.priv = priv;
    e.bsy  = bsy;
    e.flt  = flt;
    expQ.push_back(e);
    @(posedge slow_clock);
    #1;
  endtask

  initial begin
    $display("[TB] bank_mode_controller directed test");
    //            rst stp knd irq | en ctl vs ack prv bsy flt
    applyStimulus(1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    // Plain write-backs in USER, each lasting one cycle
    applyStimulus(0, 1, 1, 0,   1, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 2, 0,   1, 2, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 5, 0,   1, 5, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    // SWI enters the kernel; a step held during ENTER is only taken in KERNEL
    applyStimulus(0, 1, 3, 0,   1, 3, 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 1, 0,   0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0,   1, 1, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1,   0, 0, 0, 0, 1, 0, 0);
    // RETURN leaves the kernel; irq and step ignored during EXIT
    applyStimulus(0, 1, 4, 1,   1, 4, 0, 0, 1, 1, 0);
    applyStimulus(0, 1, 1, 1,   0, 0, 0, 0, 0, 0, 0);
    // Step beats irq in USER, irq taken on the next idle cycle
    applyStimulus(0, 1, 2, 1,   1, 2, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1,   1, 3, 1, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 1,   0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1,   0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 4, 0,   1, 4, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    // SWI beats irq; irq stays pending through KERNEL and EXIT
    applyStimulus(0, 1, 3, 1,   1, 3, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1,   0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1,   0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 4, 1,   1, 4, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1,   1, 3, 1, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0);
    // Illegal requests in KERNEL: SWI and kind 7
    applyStimulus(0, 1, 3, 0,   1, 0, 0, 0, 1, 0, 1);
    applyStimulus(0, 1, 7, 0,   1, 0, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 1);
    applyStimulus(0, 1, 4, 0,   1, 4, 0, 0, 1, 1, 1);
    applyStimulus(0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1);
    // Illegal requests in USER: RETURN and kind 6; fault sticks
    applyStimulus(0, 1, 4, 0,   1, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 6, 0,   1, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1);
    // Reset clears fault; reset during ENTER aborts the kernel entry
    applyStimulus(1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 3, 0,   1, 3, 0, 0, 0, 1, 0);
    applyStimulus(1, 1, 1, 1,   0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0,   1, 1, 0, 0, 0, 0, 0);
    // Reset wins over a pending irq
    applyStimulus(1, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);

    step    = 1'b0;
    irq_req = 1'b0;
    repeat (3) @(negedge slow_clock);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
